// File: rtl/led_breather.sv
// LED breathing sequencer: a ramp/plateau FSM steps the duty level on upstream
// ticks, and a free-running PWM turns that level into a glitch-free LED drive.
module led_breather #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tg_tick,
    input  logic                enable,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          phase,
    output logic                cycle_done
);

    typedef enum logic [1:0] {
        PH_UP     = 2'd0,
        PH_HOLD_H = 2'd1,
        PH_DOWN   = 2'd2,
        PH_HOLD_L = 2'd3
    } phase_t;

    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [PWM_BITS-1:0] LVL_STEP  = PWM_BITS'(STEP);
    localparam logic [PWM_BITS-1:0] UP_LIMIT  = LVL_MAX - LVL_STEP;
    localparam logic [15:0]         HOLD_LAST = 16'(HOLD_TICKS - 1);

    // PWM datapath
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_led;

    // Sequencer state
    phase_t              r_state;
    logic [PWM_BITS-1:0] r_level;
    logic [15:0]         r_hold_cnt;
    logic                r_cycle_done;

    phase_t              w_state_next;
    logic [PWM_BITS-1:0] w_level_next;
    logic [15:0]         w_hold_next;
    logic                w_cycle_done_next;
    logic                w_accept;
    logic                w_pwm_wrap;

    assign w_accept   = tg_tick & enable;
    assign w_pwm_wrap = (r_pwm_cnt == LVL_MAX);

    // Duty is only sampled at the period boundary so a level change never
    // produces a truncated or stretched pulse mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_led     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_led     <= (r_pwm_cnt < r_duty);
            if (w_pwm_wrap) begin
                r_duty <= r_level;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= PH_HOLD_L;
            r_level      <= '0;
            r_hold_cnt   <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_level      <= w_level_next;
            r_hold_cnt   <= w_hold_next;
            r_cycle_done <= w_cycle_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_level_next      = r_level;
        w_hold_next       = r_hold_cnt;
        w_cycle_done_next = 1'b0;
        if (w_accept) begin
            case (r_state)
                PH_UP: begin
                    // Saturating compare keeps the ramp from wrapping past MAX.
                    if (r_level >= UP_LIMIT) begin
                        w_level_next = LVL_MAX;
                        w_hold_next  = '0;
                        w_state_next = PH_HOLD_H;
                    end else begin
                        w_level_next = r_level + LVL_STEP;
                    end
                end
                PH_HOLD_H: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_hold_next  = '0;
                        w_state_next = PH_DOWN;
                    end else begin
                        w_hold_next = r_hold_cnt + 16'd1;
                    end
                end
                PH_DOWN: begin
                    if (r_level <= LVL_STEP) begin
                        w_level_next      = '0;
                        w_hold_next       = '0;
                        w_state_next      = PH_HOLD_L;
                        w_cycle_done_next = 1'b1;
                    end else begin
                        w_level_next = r_level - LVL_STEP;
                    end
                end
                PH_HOLD_L: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_hold_next  = '0;
                        w_state_next = PH_UP;
                    end else begin
                        w_hold_next = r_hold_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_next = PH_HOLD_L;
                end
            endcase
        end
    end

    assign led        = r_led;
    assign level      = r_level;
    assign phase      = r_state;
    assign cycle_done = r_cycle_done;

endmodule
